// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: prescaled tick, shared PWM counter, per-channel OFF/STEADY/BLINK/BREATHE.
// Optional macro LED_BREATHE_EN builds the breathe level/dir logic; without it mode 3 behaves as STEADY.
module led_pattern_gen #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PRESCALE = 12000,
    parameter int unsigned PWM_W    = 8,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                hwclk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_W-1:0]    cfg_duty,
    input  logic [DIV_W-1:0]    cfg_period,
    output logic [CHANNELS-1:0] led,
    output logic                tick
);

    localparam int unsigned PS_W = $clog2(PRESCALE);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);
    localparam logic [PWM_W-1:0] PWM_ONE = PWM_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STEADY  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

`ifdef LED_BREATHE_EN
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;
`endif

    logic [PS_W-1:0]     presc;
    logic [PWM_W-1:0]    pwm_cnt;
    mode_t               mode   [CHANNELS];
    logic [PWM_W-1:0]    duty   [CHANNELS];
    logic [DIV_W-1:0]    period [CHANNELS];
    logic [DIV_W-1:0]    phase  [CHANNELS];
    logic [CHANNELS-1:0] blink;
    logic [CHANNELS-1:0] wr_sel;
    logic [CHANNELS-1:0] led_next;
`ifdef LED_BREATHE_EN
    logic [PWM_W-1:0]    level  [CHANNELS];
    dir_t                dir    [CHANNELS];
`endif

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            tick    <= 1'b0;
            pwm_cnt <= '0;
            led     <= '0;
        end else begin
            tick    <= (presc == PS_LAST);
            presc   <= (presc == PS_LAST) ? '0 : presc + PS_ONE;
            pwm_cnt <= pwm_cnt + PWM_ONE;
            led     <= led_next;
        end
    end

    // Out-of-range channel numbers never match any index, so those writes drop silently.
    always_comb begin
        wr_sel = '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            wr_sel[ch] = cfg_we && (cfg_ch == CH_W'(ch));
        end
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            blink <= '0;
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                mode[ch]   <= MODE_OFF;
                duty[ch]   <= '0;
                period[ch] <= '0;
                phase[ch]  <= '0;
`ifdef LED_BREATHE_EN
                level[ch]  <= '0;
                dir[ch]    <= DIR_UP;
`endif
            end
        end else begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                // A write on a tick cycle takes priority and suppresses that cycle's step.
                if (wr_sel[ch]) begin
                    mode[ch]   <= mode_t'(cfg_mode);
                    duty[ch]   <= cfg_duty;
                    period[ch] <= cfg_period;
                    phase[ch]  <= '0;
                    blink[ch]  <= 1'b0;
`ifdef LED_BREATHE_EN
                    level[ch]  <= '0;
                    dir[ch]    <= DIR_UP;
`endif
                end else if (tick) begin
                    if (phase[ch] == period[ch]) begin
                        phase[ch] <= '0;
                        blink[ch] <= ~blink[ch];
`ifdef LED_BREATHE_EN
                        if (dir[ch] == DIR_UP) begin
                            if (level[ch] == duty[ch]) dir[ch] <= DIR_DOWN;
                            else                       level[ch] <= level[ch] + PWM_ONE;
                        end else begin
                            if (level[ch] == '0) dir[ch] <= DIR_UP;
                            else                 level[ch] <= level[ch] - PWM_ONE;
                        end
`endif
                    end else begin
                        phase[ch] <= phase[ch] + DIV_ONE;
                    end
                end
            end
        end
    end

    always_comb begin
        led_next = '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            case (mode[ch])
                MODE_OFF:     led_next[ch] = 1'b0;
                MODE_STEADY:  led_next[ch] = (pwm_cnt < duty[ch]);
                MODE_BLINK:   led_next[ch] = blink[ch] && (pwm_cnt < duty[ch]);
`ifdef LED_BREATHE_EN
                MODE_BREATHE: led_next[ch] = (pwm_cnt < level[ch]);
`else
                MODE_BREATHE: led_next[ch] = (pwm_cnt < duty[ch]);
`endif
                default:      led_next[ch] = 1'b0;
            endcase
        end
    end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised multi-channel LED driver: the next generation of the board's free-running blink counter. One prescaler produces a timebase tick. A shared PWM counter and per-channel mode, duty and period registers drive each LED as off, steady-dimmed, blinking or breathing. It sits between the board clock and the LED pins, and is configured through a one-cycle write strobe from a host/UART block.

## Interface
- CHANNELS, 4, number of LED outputs (1..16)
- PRESCALE, 12000, hwclk cycles per tick (≥2)
- PWM_W, 8, PWM counter / duty width
- DIV_W, 16, per-channel period counter width
- CH_W, derived, $clog2(CHANNELS) (min 1)

Ports:
- hwclk  in  1  board clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  config write strobe, one cycle
- cfg_ch  in  CH_W  target channel
- cfg_mode  in  2  0 OFF, 1 STEADY, 2 BLINK, 3 BREATHE
- cfg_duty  in  PWM_W  brightness / breathe ceiling
- cfg_period  in  DIV_W  ticks per blink/breathe step, minus one
- led  out  CHANNELS  registered LED drive
- tick  out  1  registered timebase pulse

## Operation
- Reset (async assert, sync release): prescaler, pwm_cnt, all channel regs, phase, blink, level = 0; dir = up; led = 0; tick = 0.
- Prescaler counts 0..PRESCALE-1 and wraps. The tick register goes high for one cycle when the count is PRESCALE-1.
- pwm_cnt: PWM_W bits, increments every cycle, wraps 2^PWM_W-1 → 0.
- cmp(x) = (pwm_cnt < x). Duty 0 gives constant off. Duty 2^PWM_W-1 gives on for 2^PWM_W-1 of every 2^PWM_W cycles.
- Per-channel step event: on tick, if phase == period, then phase ← 0 and step fires. Otherwise phase ← phase+1. Period 0 means a step on every tick.
- OFF: led = 0.
- STEADY: led = cmp(duty).
- BLINK: blink toggles on each step; led = blink & cmp(duty).
- BREATHE: on each step:
  - if dir up: when level == duty, dir ← down; otherwise level+1.
  - if dir down: when level == 0, dir ← up; otherwise level−1.
  - led = cmp(level). Each turnaround holds the level for one step.
- Config write: when cfg_we is high and cfg_ch < CHANNELS, the channel's mode, duty and period load. In the same cycle, phase, blink and level clear to 0 and dir goes up. Writes with cfg_ch ≥ CHANNELS are ignored.
- Write coincident with a tick on the same channel: the write wins, and no step fires that cycle.
- Writes to other channels do not disturb running channels.
- Lowering duty below the current level in BREATHE cannot happen, because every write clears level.

## Timing
- led[i] is registered from the cmp result: one cycle after the pwm_cnt/level value it reflects.
- tick is registered; the first tick occurs PRESCALE cycles after rst_n deasserts.
- Config takes effect on the led output two cycles after the cfg_we edge: one cycle to load, one for the led register.
- Reset asserted mid-operation forces led = 0 and tick = 0 immediately, without waiting for a clock edge.

## Configuration
- LED_BREATHE_EN defined: BREATHE mode is built, including the level/dir registers per channel.
- LED_BREATHE_EN undefined: there is no level/dir logic, and mode 3 behaves exactly as STEADY.

## Test plan
- Bench parameters: PRESCALE=4, PWM_W=4, CHANNELS=4, DIV_W=8.
- Reset: pulse rst_n low between clock edges during activity → led=0000 and tick=0 at once; first tick 4 cycles after release, then every 4 cycles.
- STEADY: ch0 with duty=4 → led[0] high 4 of every 16 cycles. duty=0 → never high. duty=15 → high 15 of 16.
- BLINK: ch1 with period=2, duty=15 → blink toggles every 3 ticks (12 cycles); led[1] dark whenever blink=0.
- BREATHE (macro on): ch2 with duty=2, period=0 → level per tick 0,1,2,2,1,0,0,1,2. With the macro off, the same write behaves as STEADY with duty 2.
- Boundaries:
  - A write to ch1 on a tick cycle → phase=0 and blink=0 afterwards.
  - cfg_ch=3 → only ch3 changes.
  - On a build with CHANNELS=3, cfg_ch=3 → no register changes.
  - pwm_cnt wraps 15 → 0 with no led glitch.
